// File: rtl/dda_param_loader_pkg.sv
// Shared constants and types for the DDA parameter loader: posit format,
// power-on parameter values, frame sync byte, address map, frame states.
package dda_param_loader_pkg;

  localparam int N  = 16;
  localparam int ES = 1;

  localparam logic [N-1:0] ICX_RST = 16'hC000;
  localparam logic [N-1:0] ICY_RST = 16'h14CD;
  localparam logic [N-1:0] MU_RST  = 16'h14DD;
  localparam logic [N-1:0] DT_RST  = 16'h7240;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] ADDR_ICX  = 8'h00;
  localparam logic [7:0] ADDR_ICY  = 8'h01;
  localparam logic [7:0] ADDR_MU   = 8'h02;
  localparam logic [7:0] ADDR_DT   = 8'h03;
  localparam logic [7:0] ADDR_CTRL = 8'h10;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ADDR,
    F_DHI,
    F_DLO,
    F_CSUM
  } frame_state_e;

  // True for the four parameter words and the control register.
  function automatic logic addr_is_valid(input logic [7:0] addr);
    return (addr == ADDR_ICX) || (addr == ADDR_ICY) || (addr == ADDR_MU) ||
           (addr == ADDR_DT)  || (addr == ADDR_CTRL);
  endfunction

endpackage

// File: rtl/dda_param_loader_if.sv
// Parameter bus from the loader to the van der Pol dda instance.
interface dda_param_loader_if;
  import dda_param_loader_pkg::*;

  logic [N-1:0] icx;
  logic [N-1:0] icy;
  logic [N-1:0] mu;
  logic [N-1:0] dt;
  logic         en_dda;
  logic         ic_load;
  logic         frame_ok;
  logic         frame_err;

  modport master (output icx, icy, mu, dt, en_dda, ic_load, frame_ok, frame_err);
  modport slave  (input  icx, icy, mu, dt, en_dda, ic_load, frame_ok, frame_err);
endinterface

// File: rtl/dda_param_loader_uart_rx.sv
// UART 8N1 receiver, LSB first. Start bit re-checked at half a bit to reject
// glitches, data and stop bits sampled at mid-bit. o_byte_valid / o_stop_err
// are single-cycle strobes issued after the stop-bit sample.
module uart_rx #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e        r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_stop_err;
  logic             w_rx;
  logic             w_tick;

  assign w_rx = r_sync[1];

  // Synchronise the asynchronous line and keep one delayed copy for edge detect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_rx};
      r_rx_prev <= w_rx;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and the per-bit sampling tick.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch appears.
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_rx_prev && !w_rx) w_state_nxt = RX_START;
      end
      RX_START: begin
        w_tick = (r_cnt == CNT_W'(HALF_BIT - 1));
        if (w_tick) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
        if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        w_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
        if (w_tick) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and output strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      if ((r_state == RX_IDLE) || w_tick) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_IDLE) r_bit_idx <= '0;
      if ((r_state == RX_DATA) && w_tick) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if ((r_state == RX_STOP) && w_tick) begin
        r_byte_valid <= w_rx;
        r_stop_err   <= !w_rx;
      end
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_stop_err   = r_stop_err;

endmodule

// File: rtl/dda_param_loader.sv
// Host-to-chip end of the DDA serial link. Decodes A5/ADDR/DHI/DLO/CSUM frames
// from the UART and writes posit16 solver parameters and the solver enable.
module dda_param_loader
  import dda_param_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int TIMEOUT_BIT = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  dda_param_loader_if.master param_bus
);

  localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BIT * CLKS_PER_BIT;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

  logic [7:0]   w_byte;
  logic         w_byte_valid;
  logic         w_stop_err;
  logic         w_timeout;
  logic         w_commit;
  logic         w_reject;

  frame_state_e r_state, w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]   r_addr, r_dhi, r_dlo;
  logic [N-1:0] r_icx, r_icy, r_mu, r_dt;
  logic         r_en_dda;
  logic         r_ic_load;
  logic         r_frame_ok;
  logic         r_frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_uart_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_stop_err  (w_stop_err)
  );

  assign w_timeout = (r_state != F_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= F_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame sequencing; a received byte takes priority over a timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    if (w_byte_valid) begin
      case (r_state)
        F_IDLE: if (w_byte == SYNC_BYTE) w_state_nxt = F_ADDR;
        F_ADDR: w_state_nxt = F_DHI;
        F_DHI:  w_state_nxt = F_DLO;
        F_DLO:  w_state_nxt = F_CSUM;
        F_CSUM: begin
          w_state_nxt = F_IDLE;
          if ((w_byte == (r_addr ^ r_dhi ^ r_dlo)) && addr_is_valid(r_addr)) w_commit = 1'b1;
          else                                                               w_reject = 1'b1;
        end
        default: w_state_nxt = F_IDLE;
      endcase
    end else if ((r_state != F_IDLE) && (w_stop_err || w_timeout)) begin
      w_state_nxt = F_IDLE;
      w_reject    = 1'b1;
    end
  end

  // Inter-byte timeout counter, restarted by every byte and held at zero in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_byte_valid || (r_state == F_IDLE)) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Capture the address and data bytes as the frame advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_dhi  <= '0;
      r_dlo  <= '0;
    end else if (w_byte_valid) begin
      if (r_state == F_ADDR) r_addr <= w_byte;
      if (r_state == F_DHI)  r_dhi  <= w_byte;
      if (r_state == F_DLO)  r_dlo  <= w_byte;
    end
  end

  // Parameter registers and status pulses; a committed word lands in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_icx       <= ICX_RST;
      r_icy       <= ICY_RST;
      r_mu        <= MU_RST;
      r_dt        <= DT_RST;
      r_en_dda    <= 1'b1;
      r_ic_load   <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ic_load   <= 1'b0;
      r_frame_ok  <= w_commit;
      r_frame_err <= w_reject;
      if (w_commit) begin
        case (r_addr)
          ADDR_ICX: begin
            r_icx     <= {r_dhi, r_dlo};
            r_ic_load <= 1'b1;
          end
          ADDR_ICY: begin
            r_icy     <= {r_dhi, r_dlo};
            r_ic_load <= 1'b1;
          end
          ADDR_MU:   r_mu     <= {r_dhi, r_dlo};
          ADDR_DT:   r_dt     <= {r_dhi, r_dlo};
          ADDR_CTRL: r_en_dda <= r_dlo[0];
          default: ;
        endcase
      end
    end
  end

  assign param_bus.icx       = r_icx;
  assign param_bus.icy       = r_icy;
  assign param_bus.mu        = r_mu;
  assign param_bus.dt        = r_dt;
  assign param_bus.en_dda    = r_en_dda;
  assign param_bus.ic_load   = r_ic_load;
  assign param_bus.frame_ok  = r_frame_ok;
  assign param_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_dda_param_loader.sv
// Self-checking bench for dda_param_loader: table of directed frames, hand-built
// corner sequences (bad stop bit, timeout, glitch, reset mid-frame, back-to-back)
// and random frames checked against a frame-level reference model.
module tb_dda_param_loader;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  dda_param_loader_if bus();

  dda_param_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .TIMEOUT_BIT(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .param_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters and the output values seen in the frame_ok cycle.
  int n_ok = 0, n_err = 0, n_icl = 0, n_icl_alone = 0;
  logic [15:0] s_icx = '0, s_icy = '0, s_mu = '0, s_dt = '0;
  logic        s_en = 1'b0;

  always @(negedge clk) begin
    if (bus.frame_ok) begin
      n_ok++;
      s_icx = bus.icx; s_icy = bus.icy; s_mu = bus.mu; s_dt = bus.dt; s_en = bus.en_dda;
    end
    if (bus.frame_err) n_err++;
    if (bus.ic_load) begin
      n_icl++;
      if (!bus.frame_ok) n_icl_alone++;
    end
  end

  // Reference model state: the parameter set the host has successfully written.
  logic [15:0] m_icx, m_icy, m_mu, m_dt;
  logic        m_en;

  task automatic model_reset();
    m_icx = 16'hC000; m_icy = 16'h14CD; m_mu = 16'h14DD; m_dt = 16'h7240; m_en = 1'b1;
  endtask

  // A frame is accepted when its checksum matches and the address is mapped.
  task automatic model_frame(input logic [7:0] a, h, l, c, output bit ok, err, icl);
    bit good;
    good = (c == (a ^ h ^ l)) && (a inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h10});
    ok   = good;
    err  = !good;
    icl  = good && (a == 8'h00 || a == 8'h01);
    if (good) begin
      if (a == 8'h00) m_icx = {h, l};
      if (a == 8'h01) m_icy = {h, l};
      if (a == 8'h02) m_mu  = {h, l};
      if (a == 8'h03) m_dt  = {h, l};
      if (a == 8'h10) m_en  = l[0];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, h, l, c);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic idle_bits(input int bits);
    rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  int ok0, err0, icl0;

  task automatic mark();
    ok0 = n_ok; err0 = n_err; icl0 = n_icl;
  endtask

  task automatic verify(input string tag, input int eok, input int eerr, input int eicl,
                        input logic [15:0] eicx, eicy, emu, edt, input logic een);
    check({tag, " frame_ok pulses"},  n_ok  - ok0,  eok);
    check({tag, " frame_err pulses"}, n_err - err0, eerr);
    check({tag, " ic_load pulses"},   n_icl - icl0, eicl);
    check({tag, " icx"}, bus.icx, eicx);
    check({tag, " icy"}, bus.icy, eicy);
    check({tag, " mu"},  bus.mu,  emu);
    check({tag, " dt"},  bus.dt,  edt);
    check({tag, " en_dda"}, bus.en_dda, een);
    if (eok > 0) begin
      check({tag, " icx at frame_ok"}, s_icx, eicx);
      check({tag, " icy at frame_ok"}, s_icy, eicy);
      check({tag, " mu at frame_ok"},  s_mu,  emu);
      check({tag, " dt at frame_ok"},  s_dt,  edt);
      check({tag, " en at frame_ok"},  s_en,  een);
    end
  endtask

  task automatic verify_model(input string tag, input int eok, input int eerr, input int eicl);
    verify(tag, eok, eerr, eicl, m_icx, m_icy, m_mu, m_dt, m_en);
  endtask

  typedef struct {
    logic [7:0]  addr, dhi, dlo, csum;
    int          ok, err, icl;
    logic [15:0] icx, icy, mu, dt;
    logic        en;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h02, 8'h12, 8'h34, 8'h24, 1, 0, 0, 16'hC000, 16'h14CD, 16'h1234, 16'h7240, 1'b1};
    vecs[1]  = '{8'h00, 8'h40, 8'h00, 8'h40, 1, 0, 1, 16'h4000, 16'h14CD, 16'h1234, 16'h7240, 1'b1};
    vecs[2]  = '{8'h10, 8'h00, 8'h00, 8'h10, 1, 0, 0, 16'h4000, 16'h14CD, 16'h1234, 16'h7240, 1'b0};
    vecs[3]  = '{8'h03, 8'h00, 8'h01, 8'h00, 0, 1, 0, 16'h4000, 16'h14CD, 16'h1234, 16'h7240, 1'b0};
    vecs[4]  = '{8'h07, 8'hAB, 8'hCD, 8'h61, 0, 1, 0, 16'h4000, 16'h14CD, 16'h1234, 16'h7240, 1'b0};
    vecs[5]  = '{8'h01, 8'h3C, 8'h00, 8'h3D, 1, 0, 1, 16'h4000, 16'h3C00, 16'h1234, 16'h7240, 1'b0};
    vecs[6]  = '{8'h10, 8'hFF, 8'h01, 8'hEE, 1, 0, 0, 16'h4000, 16'h3C00, 16'h1234, 16'h7240, 1'b1};
    vecs[7]  = '{8'h03, 8'h12, 8'h34, 8'h25, 1, 0, 0, 16'h4000, 16'h3C00, 16'h1234, 16'h1234, 1'b1};
    vecs[8]  = '{8'h11, 8'h00, 8'h01, 8'h10, 0, 1, 0, 16'h4000, 16'h3C00, 16'h1234, 16'h1234, 1'b1};
    vecs[9]  = '{8'h00, 8'hA5, 8'hA5, 8'h00, 1, 0, 1, 16'hA5A5, 16'h3C00, 16'h1234, 16'h1234, 1'b1};
    vecs[10] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 0, 1, 0, 16'hA5A5, 16'h3C00, 16'h1234, 16'h1234, 1'b1};

    // Reset state.
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    mark();
    repeat (20) @(negedge clk);
    model_reset();
    verify_model("reset", 0, 0, 0);

    // Directed frames from the table.
    foreach (vecs[i]) begin
      mark();
      send_frame(vecs[i].addr, vecs[i].dhi, vecs[i].dlo, vecs[i].csum);
      idle_bits(3);
      verify($sformatf("vec%0d", i), vecs[i].ok, vecs[i].err, vecs[i].icl,
             vecs[i].icx, vecs[i].icy, vecs[i].mu, vecs[i].dt, vecs[i].en);
    end
    m_icx = vecs[10].icx; m_icy = vecs[10].icy; m_mu = vecs[10].mu;
    m_dt  = vecs[10].dt;  m_en  = vecs[10].en;

    // Stop bit low on DHI: frame dropped, then a clean frame is accepted.
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b0);
    idle_bits(3);
    verify_model("stop_err", 0, 1, 0);
    mark();
    send_frame(8'h02, 8'h55, 8'hAA, 8'hFD);
    m_mu = 16'h55AA;
    idle_bits(3);
    verify_model("after stop_err", 1, 0, 0);

    // Inter-byte timeout after A5 01.
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    idle_bits(25);
    verify_model("timeout", 0, 1, 0);

    // Short low glitch on the idle line produces nothing.
    mark();
    rx = 1'b0;
    repeat ((CPB * 3) / 10) @(negedge clk);
    idle_bits(12);
    verify_model("glitch", 0, 0, 0);
    mark();
    send_frame(8'h01, 8'h12, 8'h00, 8'h13);
    m_icy = 16'h1200;
    idle_bits(3);
    verify_model("after glitch", 1, 0, 1);

    // Reset in the middle of DLO: everything returns to power-on values.
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    idle_bits(4);
    model_reset();
    verify_model("reset mid-frame", 0, 0, 0);

    // Two frames with zero idle between them.
    mark();
    send_frame(8'h02, 8'h01, 8'h02, 8'h01);
    send_frame(8'h03, 8'h03, 8'h04, 8'h04);
    m_mu = 16'h0102;
    m_dt = 16'h0304;
    idle_bits(3);
    verify_model("back-to-back", 2, 0, 0);

    // Random frames, some with a corrupted checksum or unmapped address.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] a, h, l, c;
      bit eok, eerr, eicl;
      case ($urandom_range(0, 5))
        0: a = 8'h00;
        1: a = 8'h01;
        2: a = 8'h02;
        3: a = 8'h03;
        4: a = 8'h10;
        default: a = 8'($urandom_range(0, 255));
      endcase
      h = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 255));
      c = a ^ h ^ l;
      if ($urandom_range(0, 4) == 0) c = c ^ 8'($urandom_range(1, 255));
      mark();
      send_frame(a, h, l, c);
      model_frame(a, h, l, c, eok, eerr, eicl);
      idle_bits(2);
      verify_model($sformatf("rand%0d a=%0h", k, a), int'(eok), int'(eerr), int'(eicl));
    end

    check("ic_load without frame_ok", n_icl_alone, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
